serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial subtractor computing `A - B - Bin` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the inverse-direction companion to the team's ripple full-adder datapath. It serves area-constrained arithmetic paths that can tolerate WIDTH-cycle latency, with a start/busy/done handshake toward the controlling FSM.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `A`  in  WIDTH  minuend; sampled on the accepting edge only.
- `B`  in  WIDTH  subtrahend; sampled on the accepting edge only.
- `Bin`  in  1  borrow-in; sampled on the accepting edge only.
- `busy`  out  1  high while bits are being processed (RUN).
- `done`  out  1  one-cycle pulse; result is valid.
- `Diff`  out  WIDTH  difference `(A - B - Bin) mod 2^WIDTH`.
- `Bout`  out  1  final borrow-out; 1 iff `A < B + Bin` (unsigned).
- `Zero`  out  1  1 iff `Diff == 0`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE with `start=1` on an edge:
  - Load the A and B shift registers.
  - Load the borrow flop with `Bin`.
  - Clear the bit counter.
  - Go to RUN.
- IDLE with `start=0`: hold. Outputs `Diff`/`Bout`/`Zero` keep their last result.
- RUN, each edge:
  - a = A_sr[0], b = B_sr[0], br = borrow flop.
  - d = a^b^br.
  - br' = (~a&b) | (~a&br) | (b&br).
  - Shift A_sr and B_sr right by one.
  - Shift d into the MSB of the result register. After WIDTH shifts, bit 0 is the LSB.
  - Borrow flop ← br'.
  - Counter increments.
- RUN, when the counter reaches WIDTH-1 on an edge:
  - That edge processes the final bit.
  - Transfer the result register to `Diff` and br' to `Bout`.
  - Compute `Zero` from the final `Diff` value.
  - Go to DONE.
- DONE: `done=1` for exactly this one cycle. Next edge goes to IDLE unconditionally.
- `start` in RUN or DONE is ignored; no queueing. Operand inputs are don't-care outside the accepting edge.
- `Diff`/`Bout`/`Zero` change only on the final RUN edge. Between operations they hold the previous result.
- Counter width is clog2(WIDTH)+1. It never wraps during a legal operation.

## Timing
- Reset values: `busy=0`, `done=0`, `Diff=0`, `Bout=0`, `Zero=1`, state=IDLE, counter=0, borrow=0.
- `rst` is asserted on an edge: all state returns to the reset values on that edge, from any state. An in-flight operation is abandoned and no `done` is produced. `rst` has priority over `start`.
- `start` is accepted at edge k:
  - `busy=1` during cycles k+1 .. k+WIDTH.
  - `done=1` and results valid in cycle k+WIDTH+1.
  - `busy=0` in that same cycle.
- Latency from the accepting edge to `done`: WIDTH+1 cycles.
- Throughput: a new `start` is accepted no earlier than edge k+WIDTH+1, the edge ending DONE. That edge moves to IDLE, so the earliest acceptance is edge k+WIDTH+2.
- Back-to-back operation: one operation every WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then idle for 5 cycles -> `busy=0`, `done=0`, `Diff=0x00`, `Bout=0`, `Zero=1` throughout.
- WIDTH=8, A=0x5A, B=0x3C, Bin=0 -> `done` exactly 9 cycles after the accepting edge; `Diff=0x1E`, `Bout=0`, `Zero=0`.
- A=0x10, B=0x20, Bin=0 -> `Diff=0xF0`, `Bout=1`, `Zero=0`. A=0x00, B=0x00, Bin=1 -> `Diff=0xFF`, `Bout=1`.
- A=B=0x77, Bin=0 -> `Diff=0x00`, `Bout=0`, `Zero=1`. A=0x78, B=0x77, Bin=1 -> `Diff=0x00`, `Zero=1`, `Bout=0`.
- Operation with A=0x5A, B=0x3C; pulse `start` with A=0xFF, B=0x01 on cycle 3 of RUN and again during DONE -> both ignored; result remains 0x1E; exactly one `done` pulse.
- Reset at cycle 4 of RUN -> outputs return to reset values on that edge; no `done`. A following start with A=0x80, B=0x01 gives `Diff=0x7F`, `Bout=0`. Then random sweep of 1000 operands against the reference `A-B-Bin`, issued back-to-back at the earliest `start` acceptance.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle between a controlling FSM and serial_subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Zero;

  modport master (
    output start, A, B, Bin,
    input  busy, done, Diff, Bout, Zero
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Diff, Bout, Zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one full-subtractor cell and a registered borrow.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, diff_q;
  logic             br_q, bout_q, zero_q, busy_q, done_q;

  logic             a, b, d, br_n, last;
  logic [WIDTH-1:0] res_n;

  always_comb begin
    a     = a_sr[0];
    b     = b_sr[0];
    d     = a ^ b ^ br_q;
    br_n  = (~a & b) | (~a & br_q) | (b & br_q);
    res_n = {d, res_sr[WIDTH-1:1]};
    last  = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // busy/done are decoded from the next state so they come straight off flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == RUN);
      done_q <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.A;
            b_sr  <= bus.B;
            br_q  <= bus.Bin;
            cnt_q <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_n;
          br_q   <= br_n;
          cnt_q  <= cnt_q + CW'(1);
          if (last) begin
            diff_q <= res_n;
            bout_q <= br_n;
            zero_q <= (res_n == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;
  assign bus.Zero = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and swept checks of serial_subtractor at WIDTH=8.
module tb_serial_subtractor;
  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] ediff, input logic ebout);
    int lat;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    for (int c = 1; c <= int'(W) + 4; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
      if (c <= int'(W)) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    end
    check({tag, "_latency"}, 32'(lat), 32'(W + 1));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_diff"}, 32'(bus.Diff), 32'(ediff));
    check({tag, "_bout"}, 32'(bus.Bout), 32'(ebout));
    check({tag, "_zero"}, 32'(bus.Zero), 32'(ediff == 8'h00));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ndone;
    logic [7:0]  ra, rb;
    logic        rbin;
    logic [8:0]  ref9;

    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state held through idle cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_diff", 32'(bus.Diff), 32'h00);
      check("rst_bout", 32'(bus.Bout), 32'd0);
      check("rst_zero", 32'(bus.Zero), 32'd1);
    end

    do_op("op5a3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    do_op("op1020", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1);
    do_op("op0000b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    do_op("op7777", 8'h77, 8'h77, 1'b0, 8'h00, 1'b0);
    do_op("op7877b", 8'h78, 8'h77, 1'b1, 8'h00, 1'b0);

    // start pulses in RUN cycle 3 and in DONE must be ignored.
    bus.start = 1'b1;
    bus.A     = 8'h5A;
    bus.B     = 8'h3C;
    bus.Bin   = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        check("ign_diff", 32'(bus.Diff), 32'h1E);
      end
      if (c >= 10) check("ign_no_restart", 32'(bus.busy), 32'd0);
      if (c == 3 || c == 9) begin
        bus.start = 1'b1;
        bus.A     = 8'hFF;
        bus.B     = 8'h01;
      end else begin
        bus.start = 1'b0;
      end
    end
    check("ign_done_count", 32'(ndone), 32'd1);
    check("ign_diff_hold", 32'(bus.Diff), 32'h1E);

    // Reset in the middle of RUN abandons the operation.
    bus.start = 1'b1;
    bus.A     = 8'h12;
    bus.B     = 8'h34;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_diff", 32'(bus.Diff), 32'h00);
    check("mid_rst_bout", 32'(bus.Bout), 32'd0);
    check("mid_rst_zero", 32'(bus.Zero), 32'd1);
    rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    check("mid_rst_no_done", 32'(ndone), 32'd0);

    do_op("op8001", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);

    // Back-to-back sweep against the 9-bit reference A - B - Bin.
    for (int i = 0; i < 1000; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'h00, rbin};
      do_op("sweep", ra, rb, rbin, ref9[7:0], ref9[8]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
